// File: rtl/accum_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : accum_sequencer (with helper accum_addsub16)
//  Purpose  : Sequential accumulator stage built around a 16-bit
//             adder-subtractor. The running accumulator drives one adder
//             operand and the streamed operand drives the other. The sum is
//             registered back on every accepted operand. Sticky unsigned
//             carry/borrow and signed-overflow status are kept for the run.
//             A held result plus status is presented to the consumer.
//  Ports    :
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    i_start        pulse: seed accumulator, clear status, begin a run
//    i_init_val     accumulator seed, sampled with i_start
//    i_op_valid     operand qualifier
//    o_op_ready     operand can be accepted this cycle (combinational)
//    i_op_data      operand value
//    i_op_sub       1 = acc - op, 0 = acc + op
//    i_op_last      final operand of the run
//    o_result       accumulator register
//    o_result_valid run complete, result and status stable
//    i_result_ack   consumer releases the result (only while done)
//    o_carry_sticky OR of unsigned carry (add) / borrow (sub) over the run
//    o_ovf_sticky   OR of two's-complement overflow over the run
//    o_trunc        run ended by operand limit rather than i_op_last
//    o_op_count     operands accepted in the current run
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 16-bit adder-subtractor.
//   i_inv (I) : 1 subtracts i_input2 (two's complement: invert plus carry-in).
//   i_sel (S) : 1 presents the arithmetic result; 0 bypasses i_input1 with a
//               zero carry-out.
//   o_outc    : raw carry-out of the 17-bit addition. For subtraction a
//               carry-out of 1 means "no borrow".
// ----------------------------------------------------------------------------
module accum_addsub16 (
    input  logic [15:0] i_input1,
    input  logic [15:0] i_input2,
    input  logic        i_inv,
    input  logic        i_sel,
    output logic [15:0] o_sum,
    output logic        o_outc
);

    logic [15:0] w_operand_b;
    logic [16:0] w_full;

    assign w_operand_b = i_inv ? ~i_input2 : i_input2;
    assign w_full      = {1'b0, i_input1} + {1'b0, w_operand_b} + {16'd0, i_inv};

    always_comb begin
        o_sum  = i_input1;
        o_outc = 1'b0;
        if (i_sel) begin
            o_sum  = w_full[15:0];
            o_outc = w_full[16];
        end
    end

endmodule

module accum_sequencer #(
    parameter int MAX_OPS = 16          // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_init_val,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic [15:0] i_op_data,
    input  logic        i_op_sub,
    input  logic        i_op_last,
    output logic [15:0] o_result,
    output logic        o_result_valid,
    input  logic        i_result_ack,
    output logic        o_carry_sticky,
    output logic        o_ovf_sticky,
    output logic        o_trunc,
    output logic [7:0]  o_op_count
);

    localparam logic [7:0] c_max_ops = 8'(MAX_OPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_acc;
    logic [7:0]  r_op_count;
    logic        r_carry_sticky;
    logic        r_ovf_sticky;
    logic        r_trunc;

    logic [15:0] w_sum;
    logic        w_outc;
    logic        w_accept;
    logic [7:0]  w_count_inc;
    logic        w_carry_evt;
    logic        w_ovf_evt;
    logic        w_set_trunc;

    // ------------------------------------------------------------------
    // Adder: accumulator on one side, streamed operand on the other.
    // ------------------------------------------------------------------
    accum_addsub16 u_addsub (
        .i_input1 (r_acc),
        .i_input2 (i_op_data),
        .i_inv    (i_op_sub),
        .i_sel    (1'b1),
        .o_sum    (w_sum),
        .o_outc   (w_outc)
    );

    // A concurrent start wins over any operand, so readiness drops with it.
    assign o_op_ready  = (r_state == ST_ACCUM) && !i_start;
    assign w_accept    = i_op_valid && o_op_ready;

    // MAX_OPS never exceeds 255, so the run terminates before this wraps.
    assign w_count_inc = r_op_count + 8'd1;

    // Adder carry-out means "carry" for add and "no borrow" for subtract.
    assign w_carry_evt = i_op_sub ? ~w_outc : w_outc;

    // Signed overflow: effective operand signs agree while result sign
    // differs from the accumulator. Subtraction flips the operand sign.
    assign w_ovf_evt   = (i_op_sub ? (r_acc[15] != i_op_data[15])
                                   : (r_acc[15] == i_op_data[15]))
                         && (w_sum[15] != r_acc[15]);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_set_trunc = 1'b0;
        if (i_start) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (i_op_last) begin
                            // op_last wins over a coincident limit: no trunc.
                            w_state_nxt = ST_DONE;
                        end else if (w_count_inc == c_max_ops) begin
                            w_state_nxt = ST_DONE;
                            w_set_trunc = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_result_ack) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and run status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc          <= 16'h0000;
            r_op_count     <= 8'd0;
            r_carry_sticky <= 1'b0;
            r_ovf_sticky   <= 1'b0;
            r_trunc        <= 1'b0;
        end else if (i_start) begin
            r_acc          <= i_init_val;
            r_op_count     <= 8'd0;
            r_carry_sticky <= 1'b0;
            r_ovf_sticky   <= 1'b0;
            r_trunc        <= 1'b0;
        end else if (w_accept) begin
            r_acc          <= w_sum;
            r_op_count     <= w_count_inc;
            r_carry_sticky <= r_carry_sticky | w_carry_evt;
            r_ovf_sticky   <= r_ovf_sticky | w_ovf_evt;
            r_trunc        <= r_trunc | w_set_trunc;
        end
    end

    assign o_result       = r_acc;
    assign o_result_valid = (r_state == ST_DONE);
    assign o_carry_sticky = r_carry_sticky;
    assign o_ovf_sticky   = r_ovf_sticky;
    assign o_trunc        = r_trunc;
    assign o_op_count     = r_op_count;

endmodule
`default_nettype wire
